// File: rtl/io_port_unit_pkg.sv
// Shared types for io_port_unit: access FSM states, address regions and
// the address-map decode used by the top level.
package io_port_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_DROP
  } state_e;

  typedef enum logic [1:0] {
    RAM,
    IO,
    EDGE,
    UNMAPPED
  } region_e;

  // The IO window is wide enough for whichever pin bank is larger.
  function automatic int unsigned io_span(input int unsigned in_size,
                                          input int unsigned out_size);
    return (in_size > out_size) ? in_size : out_size;
  endfunction

  // Map an address onto RAM / IO / EDGE / UNMAPPED.
  function automatic region_e decode_region(input int unsigned addr,
                                            input int unsigned ram_size,
                                            input int unsigned in_size,
                                            input int unsigned out_size);
    int unsigned edge_base;
    edge_base = ram_size + io_span(in_size, out_size);
    if (addr < ram_size)                  return RAM;
    else if (addr < edge_base)            return IO;
    else if (addr < edge_base + in_size)  return EDGE;
    else                                  return UNMAPPED;
  endfunction

endpackage

// File: rtl/io_port_unit_if.sv
// Four-phase access bus of io_port_unit.
//   req/write/address/data_in : requester -> unit, held stable while req=1
//   ack/data_out              : unit -> requester, one-cycle completion pulse
interface io_port_unit_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  req;
  logic                  ack;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic                  data_in;
  logic                  data_out;

  modport master (output req, write, address, data_in, input ack, data_out);
  modport slave  (input req, write, address, data_in, output ack, data_out);
endinterface

// File: rtl/io_port_unit_sync_chain.sv
// Per-pin multi-flop synchronizer bank.
//   clk, reset : clock and asynchronous active-low reset (all stages clear)
//   d          : asynchronous inputs
//   q          : synchronized outputs, STAGES cycles behind d
module sync_chain #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift register per pin; stage 0 is the metastability catcher.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(STAGES); i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/io_port_unit.sv
// Bit-addressed IO port unit: 1-bit scratch RAM, synchronized input pins,
// output latches and sticky rising-edge flags behind a four-phase bus.
//   clk, reset  : clock and asynchronous active-low reset
//   bus         : io_port_unit_if slave (req/ack/write/address/data_in/data_out)
//   input_pins  : asynchronous external inputs
//   output_pins : output latches, straight from flops
module io_port_unit
  import io_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned RAM_SIZE    = 64,
  parameter int unsigned INPUT_SIZE  = 16,
  parameter int unsigned OUTPUT_SIZE = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  io_port_unit_if.slave          bus,
  input  logic [INPUT_SIZE-1:0]  input_pins,
  output logic [OUTPUT_SIZE-1:0] output_pins
);

  localparam int unsigned IO_SPAN   = io_span(INPUT_SIZE, OUTPUT_SIZE);
  localparam int unsigned EDGE_BASE = RAM_SIZE + IO_SPAN;
  localparam int unsigned RAM_AW    = (RAM_SIZE > 1)    ? $clog2(RAM_SIZE)    : 1;
  localparam int unsigned IN_AW     = (INPUT_SIZE > 1)  ? $clog2(INPUT_SIZE)  : 1;
  localparam int unsigned OUT_AW    = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

  if (64'(EDGE_BASE) + 64'(INPUT_SIZE) > (64'd1 << ADDR_WIDTH)) begin : g_bad_map
    $error("io_port_unit: address map does not fit in ADDR_WIDTH");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("io_port_unit: SYNC_STAGES must be 2..4");
  end

  state_e                  state, state_next;
  logic                    accept;
  region_e                 region;
  logic [ADDR_WIDTH-1:0]   offset;
  logic                    read_bit;
  logic [RAM_SIZE-1:0]     ram;
  logic [INPUT_SIZE-1:0]   synced, synced_d, flags, edge_clr;

  sync_chain #(
    .WIDTH  (INPUT_SIZE),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (input_pins),
    .q     (synced)
  );

  // Address decode and read-data select.
  always_comb begin
    region   = decode_region(32'(bus.address), RAM_SIZE, INPUT_SIZE, OUTPUT_SIZE);
    offset   = bus.address;
    read_bit = 1'b0;
    case (region)
      RAM: read_bit = ram[RAM_AW'(bus.address)];
      IO: begin
        offset = bus.address - ADDR_WIDTH'(RAM_SIZE);
        if (32'(offset) < INPUT_SIZE) read_bit = synced[IN_AW'(offset)];
      end
      EDGE: begin
        offset   = bus.address - ADDR_WIDTH'(EDGE_BASE);
        read_bit = flags[IN_AW'(offset)];
      end
      default: ;
    endcase
  end

  // Access FSM; an access is accepted only on the IDLE->ACK transition.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          state_next = ACK;
          accept     = 1'b1;
        end
      end
      ACK:       state_next = bus.req ? WAIT_DROP : IDLE;
      WAIT_DROP: if (!bus.req) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Any accepted access to an EDGE address (read or write) clears its flag.
  always_comb begin
    edge_clr = '0;
    if (accept && region == EDGE) edge_clr[IN_AW'(offset)] = 1'b1;
  end

  // FSM state, ack pulse and captured read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bus.ack      <= 1'b0;
      bus.data_out <= 1'b0;
    end else begin
      state        <= state_next;
      bus.ack      <= (state_next == ACK);
      bus.data_out <= (accept && !bus.write) ? read_bit : 1'b0;
    end
  end

  // Write commit into RAM and output latches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram         <= '0;
      output_pins <= '0;
    end else if (accept && bus.write) begin
      case (region)
        RAM: ram[RAM_AW'(bus.address)] <= bus.data_in;
        IO:  if (32'(offset) < OUTPUT_SIZE) output_pins[OUT_AW'(offset)] <= bus.data_in;
        default: ;
      endcase
    end
  end

  // Sticky rising-edge flags; a same-cycle set beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      synced_d <= '0;
      flags    <= '0;
    end else begin
      synced_d <= synced;
      flags    <= (flags & ~edge_clr) | (synced & ~synced_d);
    end
  end

endmodule

// File: tb/tb_io_port_unit.sv
// Scoreboard bench for io_port_unit with a cycle-indexed pin-history model.
module tb_io_port_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned RS = 64;
  localparam int unsigned IS = 16;
  localparam int unsigned OS = 16;
  localparam int unsigned SS = 2;
  localparam int unsigned EB = RS + ((IS > OS) ? IS : OS);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IS-1:0] input_pins = '0;
  logic [OS-1:0] output_pins;
  bit            pin_rand = 1'b0;

  io_port_unit_if #(.ADDR_WIDTH(AW)) bus ();

  io_port_unit #(
    .ADDR_WIDTH  (AW),
    .RAM_SIZE    (RS),
    .INPUT_SIZE  (IS),
    .OUTPUT_SIZE (OS),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus),
    .input_pins  (input_pins),
    .output_pins (output_pins)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic  chk;
    logic  exp;
    string name;
  } exp_t;
  exp_t sb[$];

  // Reference state: RAM bits, output latches, edge flags, pin samples per edge.
  logic          ram_m [RS];
  logic [OS-1:0] out_m = '0;
  logic [IS-1:0] flags_m = '0;
  logic [IS-1:0] clr_pend = '0;
  logic [IS-1:0] ph [8] = '{default: '0};
  int            cyc = 0;

  // Pin vector sampled at edge m (zero while in reset).
  function automatic logic [IS-1:0] pin_at(input int m);
    return ph[m & 7];
  endfunction

  // The pins are seen by the bus SS edges late; a flag rises one edge after that.
  always @(posedge clk) begin
    cyc++;
    ph[cyc & 7] = rst_n ? input_pins : '0;
    if (!rst_n) flags_m = '0;
    else        flags_m = (flags_m & ~clr_pend) | (pin_at(cyc - SS) & ~pin_at(cyc - SS - 1));
    clr_pend = '0;
  end

  // Monitor: every ack consumes one scoreboard entry; data_out idles at 0.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.ack) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL spurious_ack: ack=1 with no access outstanding at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (e.chk) begin
          vectors++;
          if (bus.data_out !== e.exp) begin
            miscompares++;
            $display("FAIL %s: data_out=%b expected %b", e.name, bus.data_out, e.exp);
          end
        end
      end
    end else begin
      vectors++;
      if (bus.data_out !== 1'b0) begin
        miscompares++;
        $display("FAIL data_out_idle: data_out=%b expected 0 at %0t", bus.data_out, $time);
      end
    end
  end

  // Random pin activity, only when enabled.
  always @(negedge clk) begin
    if (pin_rand && $urandom_range(0, 3) == 0) begin
      int k;
      k = int'($urandom_range(0, IS - 1));
      input_pins[k] = ~input_pins[k];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // One four-phase access; called just after a negedge with the unit idle.
  task automatic access(input logic w, input int unsigned addr, input logic d,
                        input int hold, input string name);
    logic          exp_v;
    logic [IS-1:0] pv;
    int            k;
    int            n;
    bit            got;
    exp_v = 1'b0;
    if (addr < RS) begin
      exp_v = ram_m[addr];
      if (w) ram_m[addr] = d;
    end else if (addr < EB) begin
      k  = int'(addr - RS);
      pv = pin_at(cyc + 1 - SS);
      if (k < IS) exp_v = pv[k];
      if (w && k < OS) out_m[k] = d;
    end else if (addr < EB + IS) begin
      k = int'(addr - EB);
      exp_v = flags_m[k];
      clr_pend[k] = 1'b1;
    end
    sb.push_back('{chk: !w, exp: exp_v, name: name});
    bus.req     = 1'b1;
    bus.write   = w;
    bus.address = AW'(addr);
    bus.data_in = d;
    n = 0;
    got = 1'b0;
    while (n < 8 && !got) begin
      @(posedge clk); #1;
      n++;
      if (bus.ack) got = 1'b1;
    end
    check({name, "_ack_latency"}, got ? n : 99, 1);
    repeat (hold) begin
      @(negedge clk);
      bus.address = AW'($urandom);
      bus.write   = 1'($urandom);
      bus.data_in = 1'($urandom);
    end
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    check({name, "_outputs"}, 32'(output_pins), 32'(out_m));
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(RS); i++) ram_m[i] = 1'b0;
    out_m    = '0;
    flags_m  = '0;
    clr_pend = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 1'b0; bus.write = 1'b0; bus.address = '0; bus.data_in = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check("reset_ack", 32'(bus.ack), 0);
    check("reset_data_out", 32'(bus.data_out), 0);
    check("reset_outputs", 32'(output_pins), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic RAM write/read.
    access(1, 3, 1, 0, "wr_ram3");
    access(0, 3, 0, 0, "rd_ram3");
    access(0, 4, 0, 0, "rd_ram4");

    // Output latch set and clear.
    access(1, RS + 5, 1, 0, "wr_out5");
    check("out5_set", 32'(output_pins), 32'h0020);
    access(1, RS + 5, 0, 0, "wr_out5_clr");
    check("out5_clr", 32'(output_pins), 32'h0000);

    // Synchronized input and its edge flag with clear-on-read.
    input_pins[2] = 1'b1;
    repeat (2) @(negedge clk);
    access(0, RS + 2, 0, 0, "rd_in2");
    access(0, EB + 2, 0, 0, "rd_edge2");
    access(0, EB + 2, 0, 0, "rd_edge2_again");

    // Edge arriving on the same edge as a clearing read of that flag.
    input_pins[0] = 1'b1;
    repeat (5) @(negedge clk);
    input_pins[0] = 1'b0;
    repeat (5) @(negedge clk);
    input_pins[0] = 1'b1;
    repeat (SS) @(negedge clk);
    access(0, EB + 0, 0, 0, "rd_edge0_collide");
    access(0, EB + 0, 0, 0, "rd_edge0_kept");
    access(0, EB + 0, 0, 0, "rd_edge0_cleared");

    // Long req hold, unmapped read and write.
    access(0, 3, 0, 4, "rd_ram3_hold");
    access(0, 200, 0, 0, "rd_unmapped");
    access(1, 200, 1, 1, "wr_unmapped");
    access(0, 3, 0, 0, "rd_ram3_after_unmapped");

    // Reset during the ack of an output write.
    input_pins = '0;
    repeat (6) @(negedge clk);
    sb.push_back('{chk: 1'b0, exp: 1'b0, name: "wr_out6_abort"});
    bus.req = 1'b1; bus.write = 1'b1; bus.address = AW'(RS + 6); bus.data_in = 1'b1;
    @(posedge clk); #1;
    check("abort_ack_seen", 32'(bus.ack), 1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_ack_drop", 32'(bus.ack), 0);
    check("abort_outputs", 32'(output_pins), 0);
    bus.req = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_outputs_after", 32'(output_pins), 0);
    access(0, 3, 0, 0, "rd_ram3_after_reset");
    access(0, EB + 2, 0, 0, "rd_edge2_after_reset");

    // Randomized traffic with live pin activity.
    pin_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int unsigned a;
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, RS - 1);
        1:       a = RS + $urandom_range(0, EB - RS - 1);
        2:       a = EB + $urandom_range(0, IS - 1);
        default: a = $urandom_range(EB + IS, (1 << AW) - 1);
      endcase
      access(1'($urandom), a, 1'($urandom), int'($urandom_range(0, 2)), "rand");
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    pin_rand = 1'b0;

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
